// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-bit synchronize, debounce and edge-detect of board buttons and DIP switches
module input_conditioner #(
  parameter int                WIDTH           = 6,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0]  INVERT_MASK     = 6'b000011,
  parameter logic [WIDTH-1:0]  INIT_LEVEL      = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  accept;
  state_t                            state [WIDTH];
  logic [CW-1:0]                     cnt   [WIDTH];

  // Reset value of the chain is pre-inverted so s matches INIT_LEVEL straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL ^ INVERT_MASK}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (state[i] == PENDING) && (s[i] != level_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_out  <= INIT_LEVEL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      any_change <= |accept;
      for (int i = 0; i < WIDTH; i++) begin
        rise_pulse[i] <= accept[i] & s[i];
        fall_pulse[i] <= accept[i] & ~s[i];
        case (state[i])
          IDLE: begin
            if (s[i] != level_out[i]) begin
              state[i] <= PENDING;
              cnt[i]   <= CNT_ONE;
            end else begin
              cnt[i] <= '0;
            end
          end
          PENDING: begin
            // A return to the accepted level before the count completes is a glitch.
            if (s[i] == level_out[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              level_out[i] <= s[i];
              state[i]     <= IDLE;
              cnt[i]       <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed-vector bench for input_conditioner
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic [5:0] raw_in;
  logic [5:0] level_out;
  logic [5:0] rise_pulse;
  logic [5:0] fall_pulse;
  logic       any_change;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .WIDTH(6),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK(6'b000011),
    .INIT_LEVEL(6'b000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .level_out(level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input int lvl, input int rise, input int fall, input int anyc);
    check({tag, ".level"}, {26'b0, level_out}, lvl);
    check({tag, ".rise"},  {26'b0, rise_pulse}, rise);
    check({tag, ".fall"},  {26'b0, fall_pulse}, fall);
    check({tag, ".any"},   {31'b0, any_change}, anyc);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    reset  = 1'b1;
    raw_in = 6'b000011;
    cyc(2);
    expect_all("s1.reset", 0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      expect_all($sformatf("s1.idle%0d", k), 0, 0, 0, 0);
    end

    // Button 0 pressed (active-low pin): level change lands on the 7th edge after the step.
    raw_in = 6'b000010;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      expect_all($sformatf("s2.k%0d", k), (k >= 7) ? 'h01 : 'h00,
                 (k == 7) ? 'h01 : 'h00, 0, (k == 7) ? 1 : 0);
    end

    raw_in = 6'b000011;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      expect_all($sformatf("s6.k%0d", k), (k >= 7) ? 'h00 : 'h01,
                 0, (k == 7) ? 'h01 : 'h00, (k == 7) ? 1 : 0);
    end

    // Bounce on bit 2; the last 0->1 step is applied before cycle 5, so acceptance is at cycle 11.
    for (int j = 0; j <= 13; j++) begin
      raw_in = 6'b000011 | ((j < 9) ? (6'(pat[j]) << 2) : 6'b000100);
      cyc(1);
      expect_all($sformatf("s3.j%0d", j), (j >= 11) ? 'h04 : 'h00,
                 (j == 11) ? 'h04 : 'h00, 0, (j == 11) ? 1 : 0);
    end

    raw_in = 6'b101111;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      expect_all($sformatf("s4.k%0d", k), (k >= 7) ? 'h2c : 'h04,
                 (k == 7) ? 'h28 : 'h00, 0, (k == 7) ? 1 : 0);
    end

    // Bit 4 reaches counter 3 after five edges; reset lands on the sixth.
    raw_in = 6'b111111;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      expect_all($sformatf("s5.pend%0d", k), 'h2c, 0, 0, 0);
    end
    reset = 1'b1;
    cyc(1);
    expect_all("s5.reset", 0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      expect_all($sformatf("s5.rel%0d", k), (k >= 7) ? 'h3c : 'h00,
                 (k == 7) ? 'h3c : 'h00, 0, (k == 7) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronizes, debounces and edge-detects the raw board pushbuttons and DIP switches before they drive the HPS button and DIP-switch PIO inputs of the SoC system. Each bit has its own synchronizer chain, debounce counter and stable-level register. The block outputs clean levels for the PIO ports and one-cycle rise/fall pulses for fabric logic. It sits at the FPGA top level, between the board pins and the SoC system instance.

## Interface
- `WIDTH`, 6: number of conditioned bits. Bits [1:0] are buttons; bits [5:2] are DIP switches.
- `SYNC_STAGES`, 2: synchronizer flops per bit. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a new value must persist before it is accepted. The default is 20 ms at 50 MHz. Must be ≥ 1.
- `INVERT_MASK`, 6'b000011: bits to invert after synchronizing. Buttons are active-low on the board.
- `INIT_LEVEL`, 6'b000000: post-inversion level loaded at reset.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high.
- `raw_in`, in, WIDTH: asynchronous pin inputs.
- `level_out`, out, WIDTH: debounced level. Bits [1:0] feed the button PIO; bits [5:2] feed the DIP-switch PIO.
- `rise_pulse`, out, WIDTH: one-cycle pulse when a bit's level goes 0→1.
- `fall_pulse`, out, WIDTH: one-cycle pulse when a bit's level goes 1→0.
- `any_change`, out, 1: OR of all `rise_pulse` and `fall_pulse` bits, registered in the same cycle as the pulses.

## Operation
- Synchronizer: per bit, an SYNC_STAGES-deep flop chain on `raw_in`. The last stage is XORed with `INVERT_MASK`, giving signal `s[i]`. No logic sits between synchronizer flops.
- Counter: per bit, width `$clog2(DEBOUNCE_CYCLES+1)`. Counters never wrap.
- Per-bit FSM, two states:
  - IDLE, where `s[i]` equals `level_out[i]`: hold the counter at 0.
    - If `s[i]` differs from `level_out[i]`, go to PENDING with counter = 1.
  - PENDING:
    - If `s[i]` equals `level_out[i]`: clear the counter and return to IDLE. This is a glitch and is rejected; no pulse is issued.
    - Else if counter == DEBOUNCE_CYCLES: set `level_out[i] <= s[i]`, assert `rise_pulse[i]` or `fall_pulse[i]` for exactly one cycle, clear the counter and go to IDLE.
    - Else: increment the counter.
- With DEBOUNCE_CYCLES = 1, a bit that differs for one sampled cycle is accepted.
- Bits are fully independent. Simultaneous transitions on several bits each produce their own pulse in the same cycle, and `any_change` is a single cycle high.
- Reset:
  - All synchronizer flops load `INIT_LEVEL ^ INVERT_MASK`, so `s` equals `INIT_LEVEL`.
  - `level_out` loads `INIT_LEVEL`.
  - Counters load 0, the FSM goes to IDLE, and all pulse outputs and `any_change` load 0.
- Reset mid-PENDING discards the pending transition without issuing a pulse.
- After reset releases, a raw input that differs from INIT_LEVEL is debounced normally and does produce a pulse.

## Timing
- All outputs are registered, so there are no combinational paths from `raw_in` or `reset`.
- Latency from a clean `raw_in` step to `level_out` change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Define cycle 0 as the first edge that samples the new raw value.
  - `s` differs from cycle SYNC_STAGES onward.
  - `level_out` and the pulse update on edge SYNC_STAGES + DEBOUNCE_CYCLES.
- `rise_pulse`, `fall_pulse` and `any_change` are high in the same cycle that `level_out` first shows the new value, and low on the next cycle.
- An input that toggles with period ≤ DEBOUNCE_CYCLES never changes `level_out`.
- `reset` takes effect on the edge where it is sampled high. Outputs show reset values in the following cycle.

## Test plan
All scenarios use SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, INVERT_MASK = 6'b000011, INIT_LEVEL = 0.

1. Reset with `raw_in` = 6'b000011 (buttons released) -> `level_out` = 0, all pulses 0, and no pulse for 20 cycles afterwards.
2. Drive `raw_in[0]` 1→0 as a clean step at cycle 0 -> `level_out[0]` = 1 and `rise_pulse[0]` = 1 exactly at cycle 6, pulse gone at cycle 7, `any_change` matches the pulse.
3. Bounce `raw_in[2]` with the pattern 1,0,1,1,0,1,1,1,1 then hold 1 -> no change during the bounce; `level_out[2]` rises 2 + 4 cycles after the final 0→1 step, with a single `rise_pulse[2]`.
4. Step `raw_in[3]` and `raw_in[5]` to 1 on the same cycle -> both `level_out` bits and both rise pulses assert on the same cycle; `any_change` is high for 1 cycle only.
5. Assert `reset` while bit 4 is PENDING with counter = 3 -> no pulse is issued and `level_out[4]` = 0. After reset release with the input still 1, the bit rises 6 cycles after release.
6. Release button 0 after scenario 2 (`raw_in[0]` 0→1) -> `fall_pulse[0]` one cycle and `level_out[0]` = 0 after 6 cycles; `rise_pulse` stays 0.
